uart_rx: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_sync.sv | 28 ++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and serial frame levels,
// common to the transmitter and receiver sides of the link.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to
// RST_VAL so an idle-high line does not look active coming out of reset.
module uart_bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: d -> meta_r -> sync_r
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its centre using a cycle counter and
// hands completed bytes to a valid/ready consumer through a one-entry buffer.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rxs_s;
  rx_state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [2:0]           bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic [DATA_BITS-1:0] data_r, data_nxt_s;
  logic                 valid_r, valid_nxt_s;
  logic                 ferr_r, ferr_nxt_s;
  logic                 ovr_r, ovr_nxt_s;
  logic                 deliver_s;
  logic                 hs_s;

  uart_bit_sync #(.RST_VAL(IDLE_LEVEL)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (rx),
    .q     (rxs_s)
  );

  // Frame FSM: next state, bit timing counter, bit index and shift register
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_ONE;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    deliver_s   = 1'b0;
    ferr_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        if (rxs_s == START_LEVEL) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = '0;
          bit_nxt_s = 3'd0;
          // A start bit that is gone by mid-bit was noise, not a frame
          if (rxs_s == START_LEVEL) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = '0;
          shift_nxt_s = {rxs_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
            state_nxt_s = STOP;
            bit_nxt_s   = 3'd0;
          end else begin
            bit_nxt_s   = bit_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = '0;
          if (rxs_s == STOP_LEVEL) begin
            deliver_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      WAIT_IDLE: begin
        cnt_nxt_s = '0;
        if (rxs_s == IDLE_LEVEL) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        bit_nxt_s   = 3'd0;
      end
    endcase
  end

  assign hs_s = valid_r & byte_ready;

  // Holding buffer: a same-cycle handshake frees the slot for the new byte
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    ovr_nxt_s   = 1'b0;
    if (deliver_s) begin
      if (!valid_r || hs_s) begin
        data_nxt_s  = shift_r;
        valid_nxt_s = 1'b1;
      end else begin
        ovr_nxt_s   = 1'b1;
      end
    end else if (hs_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      ferr_r  <= ferr_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

  assign byte_data  = data_r;
  assign byte_valid = valid_r;
  assign frame_err  = ferr_r;
  assign overrun    = ovr_r;

endmodule
